// File: rtl/serial_compare_feeder_pkg.sv
// serial_cmp_pkg: shared types for the serial compare feeder.
//   state_t          - feeder FSM states
//   cmp_result_t     - captured comparator flags plus a not-one-hot error bit
//   CMP_RESULT_RESET - result value held after reset (comparator "equal" state)
//   flags_onehot()   - true when exactly one of lt/gt/eq is set
package serial_cmp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    SETTLE,
    DONE
  } state_t;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic err;
  } cmp_result_t;

  localparam cmp_result_t CMP_RESULT_RESET = '{lt: 1'b0, gt: 1'b0, eq: 1'b1, err: 1'b0};

  function automatic logic flags_onehot(input logic lt, input logic gt, input logic eq);
    logic ok;
    case ({lt, gt, eq})
      3'b100, 3'b010, 3'b001: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/serial_compare_feeder_if.sv
// serial_compare_feeder_if: operand and result handshakes of the feeder.
//   in_valid/in_ready/in_a/in_b          - operand pair, producer -> feeder
//   out_valid/out_ready/res_lt/gt/eq/err - captured result, feeder -> consumer
// Modports: slave = feeder view, master = producer/consumer view.
interface serial_compare_feeder_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic             res_lt;
  logic             res_gt;
  logic             res_eq;
  logic             res_err;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, res_lt, res_gt, res_eq, res_err
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, res_lt, res_gt, res_eq, res_err
  );

endinterface

// File: rtl/serial_compare_feeder_piso_shift.sv
// piso_shift: WIDTH-bit parallel-in, serial-out shift register, MSB first.
//   clk, reset - clock, synchronous active-high reset (clears the register)
//   load_i     - capture data_i (has priority over shift_i)
//   shift_i    - shift left by one, zero fill
//   data_i     - parallel load value
//   msb_o      - current MSB, the serial output
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] data_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; this register is small control-path state, so it is reset
  // (unlike wide data memories, which normally are not).
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end else if (shift_i) begin
      data_q <= {data_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb_o = data_q[WIDTH-1];

endmodule

// File: rtl/serial_compare_feeder.sv
// serial_compare_feeder: drives a bit-serial magnitude comparator.
// Accepts an operand pair, clears the comparator, shifts both operands out
// MSB first, waits one settle cycle, captures lt/gt/eq and returns the result.
//   clk, reset         - clock, synchronous active-high reset
//   bus (slave)        - operand and result valid/ready handshakes
//   cmp_reset          - comparator clear strobe (also high during reset)
//   cmp_a, cmp_b       - serial operand bits, zero outside SHIFT
//   cmp_lt/gt/eq       - comparator flags, captured at the end of SETTLE
module serial_compare_feeder
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_compare_feeder_if.slave  bus,
  output logic                    cmp_reset,
  output logic                    cmp_a,
  output logic                    cmp_b,
  input  logic                    cmp_lt,
  input  logic                    cmp_gt,
  input  logic                    cmp_eq
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cmp_result_t       res_q, res_d;
  logic              load, shift;
  logic              a_msb, b_msb;
  logic              accept;

  piso_shift #(.WIDTH(WIDTH)) u_shift_a (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (bus.in_a),
    .msb_o   (a_msb)
  );

  piso_shift #(.WIDTH(WIDTH)) u_shift_b (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (bus.in_b),
    .msb_o   (b_msb)
  );

  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= CMP_RESULT_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        // Counter saturates at WIDTH rather than wrapping.
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (cnt_q == CNT_LAST) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // The comparator has now seen all WIDTH bit pairs; err is advisory only.
        res_d = '{lt:  cmp_lt,
                  gt:  cmp_gt,
                  eq:  cmp_eq,
                  err: ~flags_onehot(cmp_lt, cmp_gt, cmp_eq)};
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE) & ~reset;
  assign bus.out_valid = (state_q == DONE);
  assign bus.res_lt    = res_q.lt;
  assign bus.res_gt    = res_q.gt;
  assign bus.res_eq    = res_q.eq;
  assign bus.res_err   = res_q.err;

  // Resetting this block also clears the downstream comparator.
  assign cmp_reset = reset | (state_q == CLEAR);
  assign cmp_a     = (state_q == SHIFT) & ~reset & a_msb;
  assign cmp_b     = (state_q == SHIFT) & ~reset & b_msb;

endmodule

// File: tb/tb_serial_compare_feeder.sv
module tb_serial_compare_feeder;
  import serial_cmp_pkg::*;

  localparam int W = 8;

  logic clk;
  logic reset;
  logic cmp_reset, cmp_a, cmp_b;
  logic cmp_lt, cmp_gt, cmp_eq;
  logic force_bad;

  // Reference bit-serial comparator: first differing bit (MSB first) decides.
  logic m_lt, m_gt, m_eq;

  int n_checks;
  int n_err;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           hold;
    logic         bad;
    logic         lt, gt, eq, err;
  } vec_t;

  vec_t        vecs[9];
  cmp_result_t sb_q[$];

  serial_compare_feeder_if #(.WIDTH(W)) bus ();

  serial_compare_feeder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cmp_reset (cmp_reset),
    .cmp_a     (cmp_a),
    .cmp_b     (cmp_b),
    .cmp_lt    (cmp_lt),
    .cmp_gt    (cmp_gt),
    .cmp_eq    (cmp_eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmp_reset) begin
      m_lt <= 1'b0;
      m_gt <= 1'b0;
      m_eq <= 1'b1;
    end else if (m_eq && (cmp_a != cmp_b)) begin
      m_lt <= cmp_b;
      m_gt <= cmp_a;
      m_eq <= 1'b0;
    end
  end

  assign cmp_lt = force_bad ? 1'b1 : m_lt;
  assign cmp_gt = force_bad ? 1'b1 : m_gt;
  assign cmp_eq = force_bad ? 1'b0 : m_eq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_res(input string name, input cmp_result_t e);
    check({name, ".lt"},  32'(bus.res_lt),  32'(e.lt));
    check({name, ".gt"},  32'(bus.res_gt),  32'(e.gt));
    check({name, ".eq"},  32'(bus.res_eq),  32'(e.eq));
    check({name, ".err"}, 32'(bus.res_err), 32'(e.err));
  endtask

  // One full transaction: offer operands, watch the serial stream, optionally
  // stall the result for 'hold' cycles, then take it and compare to the scoreboard.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         input logic bad, input cmp_result_t e);
    int k;
    int resets;
    logic [W-1:0] sa, sb;
    cmp_result_t exp_r;
    @(negedge clk);
    force_bad     = bad;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = (hold == 0);
    k = 0;
    while (!bus.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    sb_q.push_back(e);
    resets = 0;
    sa = '0;
    sb = '0;
    for (k = 1; k <= 3 * W; k++) begin
      @(negedge clk);
      if (k == 1) bus.in_valid = 1'b0;
      if (bus.out_valid) break;
      resets += int'(cmp_reset);
      if (k >= 2 && k <= W + 1) begin
        sa = {sa[W-2:0], cmp_a};
        sb = {sb[W-2:0], cmp_b};
      end
    end
    check("latency", 32'(k - 1), 32'(W + 2));
    check("cmp_reset_pulses", 32'(resets), 32'd1);
    check("serial_a", 32'(sa), 32'(a));
    check("serial_b", 32'(sb), 32'(b));
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check_res("hold_res", e);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    if (sb_q.size() > 0) begin
      exp_r = sb_q.pop_front();
      check_res("result", exp_r);
    end else begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end
    @(negedge clk);
    check("post_valid", 32'(bus.out_valid), 32'd0);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
    force_bad = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cmp_result_t e;
    logic [W-1:0] ra, rb;
    int k;

    vecs[0] = '{8'hA5, 8'h5A, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 8'h3C, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h7F, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'hFE, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 8'h80, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{8'h5A, 8'hA5, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    n_checks      = 0;
    n_err         = 0;
    force_bad     = 1'b0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_cmp_reset", 32'(cmp_reset), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_cmp_a", 32'(cmp_a), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("after_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("after_rst_cmp_reset", 32'(cmp_reset), 32'd0);
    check_res("after_rst_res", CMP_RESULT_RESET);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      e = '{lt: vecs[i].lt, gt: vecs[i].gt, eq: vecs[i].eq, err: vecs[i].err};
      run_txn(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].bad, e);
    end

    // Reset during the 4th SHIFT cycle discards the transaction.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 8'h11;
    bus.in_b     = 8'h22;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    repeat (5) @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_cmp_reset", 32'(cmp_reset), 32'd1);
    check("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_idle_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_cmp_a", 32'(cmp_a), 32'd0);
    check_res("rst_mid_res", CMP_RESULT_RESET);
    e = '{lt: 1'b1, gt: 1'b0, eq: 1'b0, err: 1'b0};
    run_txn(8'h01, 8'h02, 0, 1'b0, e);

    // Random operands against the golden unsigned compare.
    for (int n = 0; n < 60; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      e = '{lt: ra < rb, gt: ra > rb, eq: ra == rb, err: 1'b0};
      run_txn(ra, rb, $urandom_range(0, 2), 1'b0, e);
    end

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_compare_feeder.md
# serial_compare_feeder

Upstream driver for the bit-serial magnitude comparator. Accepts two parallel WIDTH-bit unsigned operands over a valid/ready handshake, clears the comparator, shifts both operands out MSB-first one bit per clock, then captures the comparator's lt/gt/eq flags into a registered result. The result is returned over a second valid/ready handshake.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  WIDTH  operand A, unsigned.
- in_b  input  WIDTH  operand B, unsigned.
- cmp_reset  output  1  clear strobe to the comparator; sets its state to eq=1, lt=0, gt=0.
- cmp_a  output  1  serial bit of A to the comparator.
- cmp_b  output  1  serial bit of B to the comparator.
- cmp_lt, cmp_gt, cmp_eq  input  1 each  comparator flags.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- res_lt, res_gt, res_eq  output  1 each  captured flags.
- res_err  output  1  captured flags were not exactly one-hot.

## Operation
- States: IDLE, CLEAR, SHIFT, SETTLE, DONE.
- IDLE: in_ready=1. When in_valid&in_ready, load in_a/in_b into two shift registers, clear the bit counter, and go to CLEAR.
- CLEAR: cmp_reset=1 and cmp_a=cmp_b=0 for one cycle, then go to SHIFT.
- SHIFT: cmp_a/cmp_b are the current MSBs of the shift registers. Each cycle, shift left by one (zero fill) and increment the counter. After WIDTH cycles, go to SETTLE.
- SETTLE: cmp_a=cmp_b=0, one cycle. Equal zero bits leave comparator state unchanged. At the end of this cycle, register cmp_lt/gt/eq into res_*. Set res_err = ~(exactly one flag set). Go to DONE.
- DONE: out_valid=1. res_* are held stable. On out_ready, go to IDLE. in_ready stays 0 until IDLE is re-entered, so there is no overlap between transactions.
- cmp_a/cmp_b are 0 in every state except SHIFT.
- cmp_reset = reset | (state==CLEAR), so the comparator is also cleared whenever this block is reset.
- Counter width is $clog2(WIDTH+1). It stops at WIDTH and never wraps.
- res_err is informational only: the result is still delivered and the FSM does not stall.

## Timing
- Reset (any state, including mid-SHIFT or DONE): next state IDLE. Shift registers and counter go to 0. res_lt=res_gt=0, res_eq=1, res_err=0, out_valid=0, cmp_a=cmp_b=0. in_ready=0 while reset is high and 1 from the first cycle after it. Any in-flight transaction is discarded with no result.
- Accept at edge T, with state in CLEAR during T..T+1.
- SHIFT covers cycles T+1..T+WIDTH, MSB first; bit i (MSB = WIDTH-1) appears in SHIFT cycle WIDTH-1-i.
- SETTLE is cycle T+WIDTH+1. out_valid rises after edge T+WIDTH+2.
- Accept-to-out_valid latency is WIDTH+2 cycles.
- Minimum transaction period is WIDTH+4 cycles when out_ready is held high (includes the IDLE cycle).
- in_valid while in_ready=0 is ignored. The producer must hold its operands until accepted.
- out_ready while out_valid=0 is ignored. out_valid&out_ready in DONE returns to IDLE on that edge; accept is possible one cycle later.

## Structure
- Package serial_cmp_pkg holds:
  - the state enum, state_t {IDLE, CLEAR, SHIFT, SETTLE, DONE};
  - the result struct cmp_result_t {lt, gt, eq, err};
  - the constant CMP_RESULT_RESET = {0,0,1,0}.
- Sub-module piso_shift: WIDTH-bit parallel-load, MSB-first, left-shift register with load/shift enables and a serial-out port. Instantiated twice, for A and B. The FSM and result capture live in the top module.

## Test plan
- WIDTH=8, A=8'hA5, B=8'h5A, out_ready=1 -> cmp_a serial 1,0,1,0,0,1,0,1. res_gt=1, res_lt=0, res_eq=0, res_err=0. out_valid exactly 10 cycles after accept.
- A=8'h3C, B=8'h3C -> res_eq=1 only. Then A=8'h00, B=8'hFF -> res_lt=1 only. Confirm cmp_reset pulses for one cycle per transaction.
- Back-pressure: A=8'h80, B=8'h7F, out_ready held low for 5 cycles -> out_valid and res_gt=1 held stable throughout. in_ready=0 throughout. Accept resumes one cycle after the handshake.
- Reset asserted in the 4th SHIFT cycle -> next cycle IDLE, in_ready=1, out_valid=0, res_eq=1, cmp_reset high during reset. A following transaction A=8'h01, B=8'h02 gives res_lt=1.
- Comparator model forced to report lt=gt=1 -> res_err=1, out_valid still asserted at the normal latency.
- WIDTH=2 and WIDTH=32 builds, with random operands over 500 transactions -> res_* match the golden unsigned compare. Latency is WIDTH+2 in every transaction.
